// File: rtl/pedes_request_timer.sv
// Pedestrian request front end: button synchroniser/debouncer plus wait/walk timers.
// Optional walk countdown output enabled by defining PED_COUNTDOWN_EN.
module pedes_request_timer #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned DEBOUNCE_CYC  = 500000,
    parameter int unsigned WAIT_S        = 3,
    parameter int unsigned WALK_S        = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_raw,
    output logic       button,
    output logic       timer_3s,
    output logic       timer_30s,
    output logic       walk_active,
    output logic       btn_db
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [6:0] walk_secs_left
`endif
);

    localparam int unsigned DC_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned PC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned MAX_S = (WAIT_S > WALK_S) ? WAIT_S : WALK_S;
    localparam int unsigned SC_W  = (MAX_S > 1) ? $clog2(MAX_S) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_WALK = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic              btn_db_q, btn_db_d;
    logic              btn_prev_q, btn_prev_d;
    logic              button_q, button_d;
    logic              pending_q, pending_d;
    logic              walk_active_q, walk_active_d;
    logic              timer_3s_q, timer_3s_d;
    logic              timer_30s_q, timer_30s_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic              press;
    logic              sec_tick;

    // Two-flop synchroniser followed by a stability-count debouncer
    always_comb begin
        sync1_d    = button_raw;
        sync2_d    = sync1_q;
        btn_db_d   = btn_db_q;
        dc_d       = dc_q;
        btn_prev_d = btn_db_q;
        if (sync2_q == btn_db_q) begin
            dc_d = '0;
        end else if (dc_q == DC_W'(DEBOUNCE_CYC - 1)) begin
            btn_db_d = sync2_q;
            dc_d     = '0;
        end else begin
            dc_d = dc_q + DC_W'(1);
        end
    end

    assign press    = btn_db_q & ~btn_prev_q;
    assign sec_tick = (pc_q == PC_W'(TICKS_PER_SEC - 1));

    // Request FSM; prescaler and seconds counter restart on every state entry
    always_comb begin
        state_d       = state_q;
        button_d      = button_q;
        pending_d     = pending_q;
        walk_active_d = walk_active_q;
        timer_3s_d    = 1'b0;
        timer_30s_d   = 1'b0;
        pc_d          = pc_q;
        sc_d          = sc_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                sc_d = '0;
                if (press || pending_q) begin
                    state_d   = ST_WAIT;
                    button_d  = 1'b1;
                    pending_d = 1'b0;
                end
            end
            ST_WAIT: begin
                button_d = 1'b1;
                if (sec_tick) begin
                    pc_d = '0;
                    if (sc_q == SC_W'(WAIT_S - 1)) begin
                        state_d       = ST_WALK;
                        timer_3s_d    = 1'b1;
                        button_d      = 1'b0;
                        walk_active_d = 1'b1;
                        sc_d          = '0;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_WALK: begin
                if (press) begin
                    pending_d = 1'b1;
                end
                if (sec_tick) begin
                    pc_d = '0;
                    if (sc_q == SC_W'(WALK_S - 1)) begin
                        state_d       = ST_IDLE;
                        timer_30s_d   = 1'b1;
                        walk_active_d = 1'b0;
                        sc_d          = '0;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d       = ST_IDLE;
                button_d      = 1'b0;
                pending_d     = 1'b0;
                walk_active_d = 1'b0;
                pc_d          = '0;
                sc_d          = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            dc_q          <= '0;
            btn_db_q      <= 1'b0;
            btn_prev_q    <= 1'b0;
            button_q      <= 1'b0;
            pending_q     <= 1'b0;
            walk_active_q <= 1'b0;
            timer_3s_q    <= 1'b0;
            timer_30s_q   <= 1'b0;
            pc_q          <= '0;
            sc_q          <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            dc_q          <= dc_d;
            btn_db_q      <= btn_db_d;
            btn_prev_q    <= btn_prev_d;
            button_q      <= button_d;
            pending_q     <= pending_d;
            walk_active_q <= walk_active_d;
            timer_3s_q    <= timer_3s_d;
            timer_30s_q   <= timer_30s_d;
            pc_q          <= pc_d;
            sc_q          <= sc_d;
        end
    end

    assign button      = button_q;
    assign timer_3s    = timer_3s_q;
    assign timer_30s   = timer_30s_q;
    assign walk_active = walk_active_q;
    assign btn_db      = btn_db_q;

`ifdef PED_COUNTDOWN_EN
    if (WALK_S > 127) begin : g_walk_s_range
        $error("WALK_S does not fit the 7-bit walk countdown");
    end

    logic [6:0] wsl_q, wsl_d;

    // Countdown is loaded on WALK entry and reads zero everywhere else
    always_comb begin
        wsl_d = '0;
        if (state_q == ST_WAIT && state_d == ST_WALK) begin
            wsl_d = 7'(WALK_S);
        end else if (state_q == ST_WALK && state_d == ST_WALK) begin
            wsl_d = sec_tick ? (wsl_q - 7'd1) : wsl_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wsl_q <= '0;
        end else begin
            wsl_q <= wsl_d;
        end
    end

    assign walk_secs_left = wsl_q;
`endif

endmodule
